// File: rtl/cachepool_pkg.sv
// Shared types for the CachePool outbound AXI gate.
//   quiesce_state_e          : global drain/quiesce FSM encoding.
//   spatz_axi_iwc_out_req_t  : AXI request bundle (AW, W, AR channels plus B/R ready).
//   spatz_axi_iwc_out_resp_t : AXI response bundle (AW/AR/W ready plus B, R channels).
package cachepool_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2
  } quiesce_state_e;

  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } spatz_axi_iwc_out_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } spatz_axi_iwc_out_resp_t;

endpackage

// File: rtl/cachepool_axi_out_gate_tracker.sv
// One port of the outbound AXI gate: outstanding read/write counters, pending-W
// counter, AW/AR valid-hold flops and the resulting valid/ready gating.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   run_i          : global FSM is in RUN (new AW/AR may be admitted)
//   slv_req_i/slv_resp_o : cluster side
//   mst_req_o/mst_resp_i : converter side
//   busy_o         : at least one read/write burst or W burst outstanding
//   idle_o         : busy_o low and no AW/AR currently held on the bus
module cachepool_axi_txn_tracker
  import cachepool_pkg::*;
#(
  parameter int unsigned MaxReadTxns  = 4,
  parameter int unsigned MaxWriteTxns = 4,
  parameter type         axi_req_t    = spatz_axi_iwc_out_req_t,
  parameter type         axi_resp_t   = spatz_axi_iwc_out_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      run_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      busy_o,
  output logic      idle_o
);

  localparam int unsigned RdCntW = $clog2(MaxReadTxns + 1);
  localparam int unsigned WrCntW = $clog2(MaxWriteTxns + 1);
  localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxReadTxns);
  localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWriteTxns);

  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [WrCntW-1:0] w_pend_q, w_pend_d;
  logic              ar_hold_q, ar_hold_d;
  logic              aw_hold_q, aw_hold_d;

  logic ar_allow, aw_allow, w_allow;
  logic ar_vld, aw_vld, w_vld;
  logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

  // A held request stays ungated so it is never withdrawn; rst_ni forces all
  // gated valids/readys low while reset is asserted.
  assign ar_allow = rst_ni & (ar_hold_q | (run_i & (rd_cnt_q < RdMax)));
  assign aw_allow = rst_ni & (aw_hold_q | (run_i & (wr_cnt_q < WrMax)));
  assign w_allow  = rst_ni & (w_pend_q != '0);

  assign ar_vld = slv_req_i.ar_valid & ar_allow;
  assign aw_vld = slv_req_i.aw_valid & aw_allow;
  assign w_vld  = slv_req_i.w_valid  & w_allow;

  assign ar_hs     = ar_vld & mst_resp_i.ar_ready;
  assign aw_hs     = aw_vld & mst_resp_i.aw_ready;
  assign w_last_hs = w_vld & mst_resp_i.w_ready & slv_req_i.w.last;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = ar_vld;
    mst_req_o.aw_valid = aw_vld;
    mst_req_o.w_valid  = w_vld;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & w_allow;
  end

  // Simultaneous increment and decrement cancel out.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs)      rd_cnt_d = rd_cnt_q + RdCntW'(1);
    else if (!ar_hs && r_last_hs) rd_cnt_d = rd_cnt_q - RdCntW'(1);

    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs)      wr_cnt_d = wr_cnt_q + WrCntW'(1);
    else if (!aw_hs && b_hs) wr_cnt_d = wr_cnt_q - WrCntW'(1);

    w_pend_d = w_pend_q;
    if (aw_hs && !w_last_hs)      w_pend_d = w_pend_q + WrCntW'(1);
    else if (!aw_hs && w_last_hs) w_pend_d = w_pend_q - WrCntW'(1);

    ar_hold_d = ar_hs ? 1'b0 : (ar_vld ? 1'b1 : ar_hold_q);
    aw_hold_d = aw_hs ? 1'b0 : (aw_vld ? 1'b1 : aw_hold_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      w_pend_q  <= '0;
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      w_pend_q  <= w_pend_d;
      ar_hold_q <= ar_hold_d;
      aw_hold_q <= aw_hold_d;
    end
  end

  assign busy_o = (rd_cnt_q != '0) | (wr_cnt_q != '0) | (w_pend_q != '0);
  assign idle_o = ~busy_o & ~ar_hold_q & ~aw_hold_q;

endmodule

// File: rtl/cachepool_axi_out_gate.sv
// Outbound AXI transaction gate for NumPorts cluster master ports. Each port
// limits outstanding AR/AW bursts and orders W behind AW; a global quiesce
// handshake blocks new AW/AR and acknowledges once every port is drained.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   slv_req_i/slv_resp_o [NumPorts] : cluster side
//   mst_req_o/mst_resp_i [NumPorts] : converter side
//   quiesce_req_i  : level request to drain and block
//   quiesce_ack_o  : high while fully quiesced
//   busy_o         : per-port outstanding-burst indication
module cachepool_axi_out_gate
  import cachepool_pkg::*;
#(
  parameter int unsigned NumPorts     = 2,
  parameter int unsigned MaxReadTxns  = 4,
  parameter int unsigned MaxWriteTxns = 4,
  parameter type         axi_req_t    = spatz_axi_iwc_out_req_t,
  parameter type         axi_resp_t   = spatz_axi_iwc_out_resp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_req_t            slv_req_i  [NumPorts],
  output axi_resp_t           slv_resp_o [NumPorts],
  output axi_req_t            mst_req_o  [NumPorts],
  input  axi_resp_t           mst_resp_i [NumPorts],
  input  logic                quiesce_req_i,
  output logic                quiesce_ack_o,
  output logic [NumPorts-1:0] busy_o
);

  quiesce_state_e      state_q, state_d;
  logic                ack_q, ack_d;
  logic [NumPorts-1:0] port_idle;
  logic                all_idle;
  logic                run;

  assign run      = (state_q == RUN);
  assign all_idle = &port_idle;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    cachepool_axi_txn_tracker #(
      .MaxReadTxns (MaxReadTxns),
      .MaxWriteTxns(MaxWriteTxns),
      .axi_req_t   (axi_req_t),
      .axi_resp_t  (axi_resp_t)
    ) u_trk (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .run_i     (run),
      .slv_req_i (slv_req_i[p]),
      .slv_resp_o(slv_resp_o[p]),
      .mst_req_o (mst_req_o[p]),
      .mst_resp_i(mst_resp_i[p]),
      .busy_o    (busy_o[p]),
      .idle_o    (port_idle[p])
    );
  end

  // Dropping the request always returns to RUN, even mid-drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (quiesce_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce_req_i) state_d = RUN;
        else if (all_idle)  state_d = QUIESCED;
      end
      QUIESCED: if (!quiesce_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
    ack_d = (state_d == QUIESCED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign quiesce_ack_o = ack_q;

endmodule

// File: tb/tb_cachepool_axi_out_gate.sv
module tb_cachepool_axi_out_gate;
  import cachepool_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic qreq = 1'b0;
  logic ack;
  logic [1:0] busy;

  spatz_axi_iwc_out_req_t  slv_req  [2];
  spatz_axi_iwc_out_req_t  mst_req  [2];
  spatz_axi_iwc_out_resp_t slv_resp [2];
  spatz_axi_iwc_out_resp_t mst_resp [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_ar0[$];
  logic [31:0] q_ar1[$];
  logic [31:0] q_w[$];

  always #5 clk = ~clk;

  cachepool_axi_out_gate #(
    .NumPorts    (2),
    .MaxReadTxns (4),
    .MaxWriteTxns(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .slv_req_i    (slv_req),
    .slv_resp_o   (slv_resp),
    .mst_req_o    (mst_req),
    .mst_resp_i   (mst_resp),
    .quiesce_req_i(qreq),
    .quiesce_ack_o(ack),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input bit has, input logic [31:0] obs,
                        input logic [31:0] exp);
    n_cmp++;
    assert (has && obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (queued=%0d)", tag, obs, exp, has);
    end
  endtask

  // Scoreboard sampling on the falling edge, then advance to just after the
  // next rising edge where the next step's stimulus is driven.
  task automatic cyc();
    logic [31:0] e;
    bit          h;
    @(negedge clk);
    if (mst_req[0].ar_valid && mst_resp[0].ar_ready) begin
      h = (q_ar0.size() != 0);
      e = h ? q_ar0.pop_front() : 32'hx;
      sb_chk("sb_ar0", h, mst_req[0].ar.addr, e);
    end
    if (mst_req[1].ar_valid && mst_resp[1].ar_ready) begin
      h = (q_ar1.size() != 0);
      e = h ? q_ar1.pop_front() : 32'hx;
      sb_chk("sb_ar1", h, mst_req[1].ar.addr, e);
    end
    for (int p = 0; p < 2; p++) begin
      if (mst_req[p].w_valid && mst_resp[p].w_ready) begin
        h = (q_w.size() != 0);
        e = h ? q_w.pop_front() : 32'hx;
        sb_chk("sb_w", h, mst_req[p].w.data, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      slv_req[p]  = '0;
      mst_resp[p] = '0;
    end

    // ---- reset: gated channels low, R/B pass through ----
    slv_req[0].ar_valid  = 1'b1;
    slv_req[0].aw_valid  = 1'b1;
    slv_req[0].w_valid   = 1'b1;
    slv_req[0].w.last    = 1'b1;
    mst_resp[0].ar_ready = 1'b1;
    mst_resp[0].aw_ready = 1'b1;
    mst_resp[0].w_ready  = 1'b1;
    mst_resp[0].b_valid  = 1'b1;
    mst_resp[0].r_valid  = 1'b1;
    #2;
    chk("rst_mst_ar_valid", mst_req[0].ar_valid, 0);
    chk("rst_mst_aw_valid", mst_req[0].aw_valid, 0);
    chk("rst_mst_w_valid", mst_req[0].w_valid, 0);
    chk("rst_slv_ar_ready", slv_resp[0].ar_ready, 0);
    chk("rst_slv_aw_ready", slv_resp[0].aw_ready, 0);
    chk("rst_slv_w_ready", slv_resp[0].w_ready, 0);
    chk("rst_slv_b_valid", slv_resp[0].b_valid, 1);
    chk("rst_slv_r_valid", slv_resp[0].r_valid, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    for (int p = 0; p < 2; p++) begin
      slv_req[p]  = '0;
      mst_resp[p] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- read limit on port 0 ----
    mst_resp[0].ar_ready = 1'b1;
    slv_req[0].r_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req[0].ar_valid = 1'b1;
      slv_req[0].ar.addr  = 32'h100 + 32'(i);
      q_ar0.push_back(slv_req[0].ar.addr);
      #1;
      chk("lim_ar_ready", slv_resp[0].ar_ready, 1);
      cyc();
    end
    slv_req[0].ar.addr = 32'h104;
    #1;
    chk("lim_5th_gated", mst_req[0].ar_valid, 0);
    chk("lim_5th_rdy", slv_resp[0].ar_ready, 0);
    chk("lim_busy", busy, 2'b01);
    cyc();
    #1;
    chk("lim_5th_gated2", mst_req[0].ar_valid, 0);
    mst_resp[0].r_valid = 1'b1;
    mst_resp[0].r.last  = 1'b1;
    #1;
    chk("lim_strict", mst_req[0].ar_valid, 0);
    q_ar0.push_back(32'h104);
    cyc();
    mst_resp[0].r_valid = 1'b0;
    #1;
    chk("lim_5th_issue", mst_req[0].ar_valid, 1);
    cyc();
    // full again; R.last frees one, then AR and R.last in the same cycle
    slv_req[0].ar.addr  = 32'h105;
    mst_resp[0].r_valid = 1'b1;
    #1;
    chk("lim_6th_gated", mst_req[0].ar_valid, 0);
    cyc();
    q_ar0.push_back(32'h105);
    #1;
    chk("simul_ar_valid", mst_req[0].ar_valid, 1);
    cyc();
    mst_resp[0].r_valid = 1'b0;
    slv_req[0].ar.addr  = 32'h106;
    q_ar0.push_back(32'h106);
    #1;
    chk("simul_cnt_kept", mst_req[0].ar_valid, 1);
    cyc();
    slv_req[0].ar.addr = 32'h107;
    #1;
    chk("simul_full", mst_req[0].ar_valid, 0);
    chk("simul_full_rdy", slv_resp[0].ar_ready, 0);
    cyc();
    slv_req[0].ar_valid = 1'b0;
    mst_resp[0].r_valid = 1'b1;
    repeat (4) cyc();
    mst_resp[0].r_valid = 1'b0;
    #1;
    chk("rd_drained_busy", busy, 0);

    // ---- W ahead of AW on port 0 ----
    mst_resp[0].w_ready  = 1'b1;
    mst_resp[0].aw_ready = 1'b1;
    slv_req[0].b_ready   = 1'b1;
    slv_req[0].w_valid   = 1'b1;
    slv_req[0].w.data    = 32'hCAFE0001;
    slv_req[0].w.last    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_early_gated", mst_req[0].w_valid, 0);
      chk("w_early_rdy", slv_resp[0].w_ready, 0);
      cyc();
    end
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].aw.addr  = 32'h200;
    q_w.push_back(32'hCAFE0001);
    #1;
    chk("aw_issue", mst_req[0].aw_valid, 1);
    chk("w_no_bypass", mst_req[0].w_valid, 0);
    cyc();
    slv_req[0].aw_valid = 1'b0;
    #1;
    chk("w_after_aw", mst_req[0].w_valid, 1);
    chk("w_busy", busy, 2'b01);
    cyc();
    slv_req[0].w_valid  = 1'b0;
    mst_resp[0].b_valid = 1'b1;
    #1;
    chk("wr_busy_pre_b", busy, 2'b01);
    cyc();
    mst_resp[0].b_valid = 1'b0;
    #1;
    chk("wr_busy_after_b", busy, 0);

    // ---- quiesce with 3 reads and 2 writes on port 1 ----
    mst_resp[1].ar_ready = 1'b1;
    mst_resp[1].aw_ready = 1'b1;
    mst_resp[1].w_ready  = 1'b1;
    slv_req[1].r_ready   = 1'b1;
    slv_req[1].b_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req[1].ar_valid = 1'b1;
      slv_req[1].ar.addr  = 32'h400 + 32'(i);
      q_ar1.push_back(slv_req[1].ar.addr);
      #1;
      cyc();
    end
    slv_req[1].ar_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slv_req[1].aw_valid = 1'b1;
      slv_req[1].aw.addr  = 32'h500 + 32'(i);
      #1;
      cyc();
    end
    slv_req[1].aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slv_req[1].w_valid = 1'b1;
      slv_req[1].w.data  = 32'hD00D0000 + 32'(i);
      slv_req[1].w.last  = 1'b1;
      q_w.push_back(slv_req[1].w.data);
      #1;
      cyc();
    end
    slv_req[1].w_valid = 1'b0;
    #1;
    chk("q_busy_p1", busy, 2'b10);
    qreq = 1'b1;
    cyc();
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].ar.addr  = 32'h600;
    slv_req[1].aw_valid = 1'b1;
    slv_req[1].aw.addr  = 32'h700;
    #1;
    chk("q_block_ar0", mst_req[0].ar_valid, 0);
    chk("q_block_ar0_rdy", slv_resp[0].ar_ready, 0);
    chk("q_block_aw1", mst_req[1].aw_valid, 0);
    chk("q_ack_draining", ack, 0);
    cyc();
    slv_req[0].ar_valid = 1'b0;
    slv_req[1].aw_valid = 1'b0;
    mst_resp[1].r_valid = 1'b1;
    mst_resp[1].r.last  = 1'b1;
    repeat (3) begin
      #1;
      chk("q_ack_rd_pending", ack, 0);
      cyc();
    end
    mst_resp[1].r_valid = 1'b0;
    mst_resp[1].b_valid = 1'b1;
    repeat (2) begin
      #1;
      chk("q_ack_wr_pending", ack, 0);
      cyc();
    end
    mst_resp[1].b_valid = 1'b0;
    #1;
    chk("q_ack_not_yet", ack, 0);
    chk("q_busy_drained", busy, 0);
    cyc();
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].ar.addr  = 32'h601;
    #1;
    chk("q_ack_rise", ack, 1);
    chk("q_busy_at_ack", busy, 0);
    chk("q_quiesced_block", mst_req[0].ar_valid, 0);
    slv_req[0].ar_valid = 1'b0;
    qreq = 1'b0;
    cyc();
    #1;
    chk("q_ack_fall", ack, 0);

    // ---- held AR survives quiesce ----
    mst_resp[0].ar_ready = 1'b0;
    slv_req[0].ar_valid  = 1'b1;
    slv_req[0].ar.addr   = 32'h800;
    #1;
    chk("hold_present", mst_req[0].ar_valid, 1);
    qreq = 1'b1;
    cyc();
    #1;
    chk("hold_keep", mst_req[0].ar_valid, 1);
    cyc();
    #1;
    chk("hold_keep2", mst_req[0].ar_valid, 1);
    chk("hold_ack", ack, 0);
    q_ar0.push_back(32'h800);
    mst_resp[0].ar_ready = 1'b1;
    #1;
    cyc();
    slv_req[0].ar_valid = 1'b0;
    #1;
    chk("hold_busy", busy, 2'b01);
    chk("hold_ack_wait", ack, 0);
    cyc();
    #1;
    chk("hold_ack_wait_r", ack, 0);
    mst_resp[0].r_valid = 1'b1;
    mst_resp[0].r.last  = 1'b1;
    cyc();
    mst_resp[0].r_valid = 1'b0;
    #1;
    chk("hold_ack_not_yet", ack, 0);
    cyc();
    #1;
    chk("hold_ack_rise", ack, 1);
    qreq = 1'b0;
    cyc();

    // ---- quiesce dropped during DRAIN ----
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].ar.addr  = 32'h900;
    q_ar0.push_back(32'h900);
    #1;
    cyc();
    slv_req[0].ar_valid = 1'b0;
    qreq = 1'b1;
    #1;
    cyc();
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].ar.addr  = 32'h901;
    #1;
    chk("drain_block", mst_req[0].ar_valid, 0);
    chk("drain_ack", ack, 0);
    qreq = 1'b0;
    cyc();
    q_ar0.push_back(32'h901);
    #1;
    chk("drop_resume_ar", mst_req[0].ar_valid, 1);
    chk("drop_ack", ack, 0);
    cyc();
    slv_req[0].ar_valid = 1'b0;
    mst_resp[0].r_valid = 1'b1;
    #1;
    chk("drop_ack2", ack, 0);
    repeat (2) cyc();
    mst_resp[0].r_valid = 1'b0;
    #1;
    chk("drop_busy", busy, 0);

    // ---- reset asserted mid-burst ----
    mst_resp[1].aw_ready = 1'b1;
    slv_req[0].ar_valid  = 1'b1;
    slv_req[0].ar.addr   = 32'hA00;
    q_ar0.push_back(32'hA00);
    slv_req[1].aw_valid  = 1'b1;
    slv_req[1].aw.addr   = 32'hB00;
    #1;
    cyc();
    slv_req[0].ar_valid = 1'b0;
    slv_req[1].aw_valid = 1'b0;
    #1;
    chk("mid_busy_pre", busy, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy, 0);
    chk("mid_ack_rst", ack, 0);
    cyc();
    #1;
    chk("mid_busy_next", busy, 0);
    rst_n = 1'b1;
    cyc();
    slv_req[0].ar_valid = 1'b1;
    slv_req[0].ar.addr  = 32'hA01;
    q_ar0.push_back(32'hA01);
    #1;
    chk("post_rst_ar", mst_req[0].ar_valid, 1);
    cyc();
    slv_req[0].ar_valid = 1'b0;
    #1;
    chk("post_rst_busy", busy, 2'b01);

    chk("sb_ar0_left", q_ar0.size(), 0);
    chk("sb_ar1_left", q_ar1.size(), 0);
    chk("sb_w_left", q_w.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
